// File: rtl/pulse_width_monitor.sv
// Edge detector and high-pulse width meter for a serial bit stream.
// Measured widths are queued in a small FIFO and read out over valid/ready.
module pulse_width_monitor #(
   parameter int unsigned CNT_W = 8,
   parameter int unsigned DEPTH = 4,
   parameter int unsigned AW    = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in,
   input  logic             en,
   output logic             rise_pulse,
   output logic             fall_pulse,
   output logic [CNT_W-1:0] rise_cnt,
   output logic [CNT_W-1:0] fall_cnt,
   output logic [CNT_W-1:0] pw_data,
   output logic             pw_valid,
   input  logic             pw_ready,
   output logic             overflow
);

   localparam logic [CNT_W-1:0] CntMax  = '1;
   localparam logic [AW:0]      FullCnt = (AW+1)'(DEPTH);

   logic             in_q, in_d;
   logic             rise_q, rise_d;
   logic             fall_q, fall_d;
   logic [CNT_W-1:0] rise_cnt_q, rise_cnt_d;
   logic [CNT_W-1:0] fall_cnt_q, fall_cnt_d;
   logic [CNT_W-1:0] wcnt_q, wcnt_d;
   logic             overflow_q, overflow_d;

   logic [CNT_W-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [AW:0]      count_q, count_d;

   logic rise_smp, fall_smp, high_smp;
   logic full, pop, push_ok, drop;

   // Sample classification; all gated by en so a frozen path sees no edges.
   assign rise_smp = en & in & ~in_q;
   assign fall_smp = en & ~in & in_q;
   assign high_smp = en & in & in_q;

   assign full     = (count_q == FullCnt);
   assign pop      = (count_q != '0) & pw_ready;
   // A full FIFO still accepts a width when the head leaves in the same cycle.
   assign push_ok  = fall_smp & (~full | pop);
   assign drop     = fall_smp & full & ~pop;

   always_comb begin
      in_d       = in_q;
      rise_d     = 1'b0;
      fall_d     = 1'b0;
      rise_cnt_d = rise_cnt_q;
      fall_cnt_d = fall_cnt_q;
      wcnt_d     = wcnt_q;
      overflow_d = overflow_q | drop;

      if (en) begin
         in_d   = in;
         rise_d = rise_smp;
         fall_d = fall_smp;
      end

      if (rise_smp && (rise_cnt_q != CntMax)) begin
         rise_cnt_d = rise_cnt_q + 1'b1;
      end
      if (fall_smp && (fall_cnt_q != CntMax)) begin
         fall_cnt_d = fall_cnt_q + 1'b1;
      end

      if (rise_smp) begin
         wcnt_d = CNT_W'(1);
      end else if (high_smp) begin
         wcnt_d = (wcnt_q != CntMax) ? wcnt_q + 1'b1 : wcnt_q;
      end else if (fall_smp) begin
         wcnt_d = '0;
      end
   end

   always_comb begin
      wr_ptr_d = push_ok ? wr_ptr_q + 1'b1 : wr_ptr_q;
      rd_ptr_d = pop     ? rd_ptr_q + 1'b1 : rd_ptr_q;
      unique case ({push_ok, pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         in_q       <= 1'b0;
         rise_q     <= 1'b0;
         fall_q     <= 1'b0;
         rise_cnt_q <= '0;
         fall_cnt_q <= '0;
         wcnt_q     <= '0;
         overflow_q <= 1'b0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         for (int i = 0; i < int'(DEPTH); i++) begin
            mem_q[i] <= '0;
         end
      end else begin
         in_q       <= in_d;
         rise_q     <= rise_d;
         fall_q     <= fall_d;
         rise_cnt_q <= rise_cnt_d;
         fall_cnt_q <= fall_cnt_d;
         wcnt_q     <= wcnt_d;
         overflow_q <= overflow_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         if (push_ok) begin
            mem_q[wr_ptr_q] <= wcnt_q;
         end
      end
   end

   assign rise_pulse = rise_q;
   assign fall_pulse = fall_q;
   assign rise_cnt   = rise_cnt_q;
   assign fall_cnt   = fall_cnt_q;
   assign overflow   = overflow_q;
   assign pw_valid   = (count_q != '0);
   assign pw_data    = mem_q[rd_ptr_q];

endmodule

// File: tb/tb_pulse_width_monitor.sv
// Directed bench for pulse_width_monitor: a vector table for reset and a basic
// pulse, then hand-written sequences for FIFO overflow, saturation, reset and en.
module tb_pulse_width_monitor;

   localparam int CNT_W = 8;

   logic             clk = 1'b0;
   logic             rst, en, in, pw_ready;
   logic             rise_pulse, fall_pulse, pw_valid, overflow;
   logic [CNT_W-1:0] rise_cnt, fall_cnt, pw_data;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   pulse_width_monitor #(.CNT_W(CNT_W), .DEPTH(4), .AW(2)) dut (
      .clk        (clk),
      .rst        (rst),
      .in         (in),
      .en         (en),
      .rise_pulse (rise_pulse),
      .fall_pulse (fall_pulse),
      .rise_cnt   (rise_cnt),
      .fall_cnt   (fall_cnt),
      .pw_data    (pw_data),
      .pw_valid   (pw_valid),
      .pw_ready   (pw_ready),
      .overflow   (overflow)
   );

   typedef struct {
      bit rst, en, in, rdy;
      int rise, fall, rc, fc, valid, data, ovf;
   } vec_t;

   vec_t vecs[9];

   task automatic chk(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_all(input string tag, input int r, input int f, input int rc,
                          input int fc, input int v, input int d, input int o);
      chk({tag, "_rise"}, int'(rise_pulse), r);
      chk({tag, "_fall"}, int'(fall_pulse), f);
      chk({tag, "_rcnt"}, int'(rise_cnt), rc);
      chk({tag, "_fcnt"}, int'(fall_cnt), fc);
      chk({tag, "_valid"}, int'(pw_valid), v);
      if (v != 0) chk({tag, "_data"}, int'(pw_data), d);
      chk({tag, "_ovf"}, int'(overflow), o);
   endtask

   initial begin
      //          rst en in rdy  rise fall rc fc valid data ovf
      vecs[0] = '{0, 1, 0, 1,   0, 0, 0, 0, 0, 0, 0};
      vecs[1] = '{1, 1, 0, 1,   0, 0, 0, 0, 0, 0, 0};
      vecs[2] = '{1, 1, 0, 1,   0, 0, 0, 0, 0, 0, 0};
      vecs[3] = '{1, 1, 0, 1,   0, 0, 0, 0, 0, 0, 0};
      vecs[4] = '{1, 1, 1, 1,   1, 0, 1, 0, 0, 0, 0};
      vecs[5] = '{1, 1, 1, 1,   0, 0, 1, 0, 0, 0, 0};
      vecs[6] = '{1, 1, 1, 1,   0, 0, 1, 0, 0, 0, 0};
      vecs[7] = '{1, 1, 0, 1,   0, 1, 1, 1, 1, 3, 0};
      vecs[8] = '{1, 1, 0, 1,   0, 0, 1, 1, 0, 0, 0};

      rst = 1'b0; en = 1'b1; in = 1'b0; pw_ready = 1'b1;

      // Reset, idle, and a single 3-cycle pulse
      for (int i = 0; i < 9; i++) begin
         rst = vecs[i].rst; en = vecs[i].en; in = vecs[i].in; pw_ready = vecs[i].rdy;
         tick();
         chk_all($sformatf("vec%0d", i), vecs[i].rise, vecs[i].fall, vecs[i].rc,
                 vecs[i].fc, vecs[i].valid, vecs[i].data, vecs[i].ovf);
      end

      // Widths 1..5 with consumer stalled: fifth width is dropped
      pw_ready = 1'b0;
      for (int w = 1; w <= 5; w++) begin
         in = 1'b1;
         repeat (w) tick();
         in = 1'b0;
         tick();
         chk($sformatf("t3_valid%0d", w), int'(pw_valid), 1);
         chk($sformatf("t3_head%0d", w), int'(pw_data), 1);
         chk($sformatf("t3_ovf%0d", w), int'(overflow), (w == 5) ? 1 : 0);
         chk($sformatf("t3_rc%0d", w), int'(rise_cnt), 1 + w);
         chk($sformatf("t3_fc%0d", w), int'(fall_cnt), 1 + w);
      end
      pw_ready = 1'b1;
      for (int k = 2; k <= 4; k++) begin
         tick();
         chk($sformatf("t3_drain_valid%0d", k), int'(pw_valid), 1);
         chk($sformatf("t3_drain_data%0d", k), int'(pw_data), k);
      end
      tick();
      chk("t3_empty", int'(pw_valid), 0);
      chk("t3_ovf_sticky", int'(overflow), 1);

      // Long pulse saturates the width; many short pulses saturate the counters
      in = 1'b1;
      repeat (300) tick();
      in = 1'b0;
      tick();
      chk("t4_valid", int'(pw_valid), 1);
      chk("t4_width_sat", int'(pw_data), 255);
      chk("t4_rc", int'(rise_cnt), 7);
      chk("t4_fc", int'(fall_cnt), 7);
      for (int i = 0; i < 260; i++) begin
         in = 1'b1;
         tick();
         in = 1'b0;
         tick();
      end
      chk("t4_rc_sat", int'(rise_cnt), 255);
      chk("t4_fc_sat", int'(fall_cnt), 255);
      chk("t4_last_width", int'(pw_data), 1);

      // Reset in the third cycle of a high pulse
      pw_ready = 1'b0;
      in = 1'b0;
      tick();
      in = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      tick();
      chk_all("t5_rst", 0, 0, 0, 0, 0, 0, 0);
      rst = 1'b1;
      tick();
      chk_all("t5_rise", 1, 0, 1, 0, 0, 0, 0);
      tick();
      chk("t5_rise_once", int'(rise_pulse), 0);
      in = 1'b0;
      tick();
      chk_all("t5_fall", 0, 1, 1, 1, 1, 2, 0);

      // en=0 freezes sampling while pop still works
      in = 1'b1;
      tick();
      chk_all("t6_rise", 1, 0, 2, 1, 1, 2, 0);
      en = 1'b0;
      in = 1'b0;
      tick();
      chk_all("t6_frz0", 0, 0, 2, 1, 1, 2, 0);
      in = 1'b1;
      tick();
      chk_all("t6_frz1", 0, 0, 2, 1, 1, 2, 0);
      in = 1'b0;
      pw_ready = 1'b1;
      tick();
      chk_all("t6_frz2_pop", 0, 0, 2, 1, 0, 0, 0);
      pw_ready = 1'b0;
      in = 1'b1;
      tick();
      chk_all("t6_frz3", 0, 0, 2, 1, 0, 0, 0);
      in = 1'b0;
      en = 1'b1;
      tick();
      chk_all("t6_fall_on_en", 0, 1, 2, 2, 1, 1, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
